filter_sweep_ctrl: RTL and testbench
====================================

# filter_sweep_ctrl

Test sequencer for the filter bench. It drives the exponential signal generator's `test_overlay` / `test_rate` / `test_delay` controls through a programmed sweep of delay values. At each delay point it waits a settle interval, then measures the peak of a filter output over a fixed window. Each point's result is reported over a valid/ready handshake. It sits beside the filter top level, feeding the generator controls and observing one filter output (e.g. `output_data_v4`).

## Interface

Parameters:
- `SIZE_DELAY`, 8: width of generator delay control.
- `SIZE_FILTER_DATA`, 16: width of observed filter output; signed two's complement.
- `SIZE_CNT`, 16: width of settle and window counters.

Ports:
- `clk`  in  1  single system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sweep; ignored while `busy`.
- `cfg_overlay`  in  1  overlay setting applied for the whole sweep.
- `cfg_rate`  in  1  rate setting applied for the whole sweep.
- `cfg_delay_first`  in  SIZE_DELAY  first delay point.
- `cfg_delay_last`  in  SIZE_DELAY  last allowed delay point (inclusive).
- `cfg_delay_step`  in  SIZE_DELAY  delay increment; 0 means single point.
- `cfg_settle_len`  in  SIZE_CNT  settle cycles before measuring; 0 means no settle.
- `cfg_window_len`  in  SIZE_CNT  measure cycles; 0 treated as 1.
- `filter_data`  in  SIZE_FILTER_DATA  observed filter output, signed.
- `result_ready`  in  1  consumer accepts result.
- `test_overlay`  out  1  to generator.
- `test_rate`  out  1  to generator.
- `test_delay`  out  SIZE_DELAY  to generator.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `result_valid`  out  1  result fields valid.
- `result_delay`  out  SIZE_DELAY  delay point of this result.
- `result_peak`  out  SIZE_FILTER_DATA  signed maximum of `filter_data` in the window.
- `result_peak_pos`  out  SIZE_CNT  window index (0-based) of the peak.

## Operation

- All `cfg_*` inputs are latched on the accepted `start`. Later changes have no effect until the next sweep.
- FSM states:
  - IDLE: on `start`, go to SETTLE (or MEASURE if settle_len=0); load `test_*`, set `busy`.
  - SETTLE: count settle_len cycles, then go to MEASURE.
  - MEASURE: sample `filter_data` for window_len cycles.
    - First sample initialises the peak.
    - A later sample replaces the peak only if strictly greater (signed), so ties keep the earliest position.
    - After the last sample, go to REPORT.
  - REPORT: hold `result_valid` and the result fields stable until `result_ready`. On transfer:
    - If another point exists: `test_delay` is updated and the FSM enters SETTLE (or MEASURE).
    - Otherwise: pulse `done`, clear `busy`, go to IDLE.
- Next-point rule:
  - next = `test_delay` + step, computed in SIZE_DELAY+1 bits.
  - Another point exists only if step≠0, there is no carry out, and next ≤ delay_last (unsigned).
  - If delay_first > delay_last, exactly one point is measured, at delay_first.
- `test_overlay`/`test_rate`/`test_delay` are stable throughout SETTLE and MEASURE. After the sweep they hold their last values.
- Reset (asynchronous, any state):
  - FSM returns to IDLE.
  - All outputs go to 0: `test_*`, `busy`, `done`, `result_valid`, and all result fields.
  - A sweep interrupted by reset is abandoned; no partial result is reported.

## Timing

- `start` sampled high at cycle 0 in IDLE:
  - `busy`, `test_*` take effect at cycle 1.
  - SETTLE occupies cycles 1..S.
  - MEASURE samples `filter_data` at cycles S+1..S+W.
  - `result_valid` rises at cycle S+W+1.
- With `result_ready` held high, the transfer happens at cycle S+W+1. The new `test_delay` and the next SETTLE start at cycle S+W+2, so the per-point period is S+W+1 cycles.
- Final transfer at cycle T: `done`=1 and `busy`=0 at cycle T+1; `start` is accepted again from cycle T+1.
- `start` while `busy` is ignored, including in the same cycle as the final transfer.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- Reset mid-MEASURE: assert `reset` → all outputs 0 in the same cycle, `result_valid` never rises. After release, `start` produces a normal first point.
- Basic sweep: first=2, last=8, step=3, settle=4, window=5, ready=1 → results at delay 2, 5, 8; valid rises at cycles 10, 20, 30; `done` at cycle 31.
- Peak tracking: window=6, filter_data = -5, 7, 3, 7, -100, 6 → result_peak=7, result_peak_pos=1.
- Backpressure: ready=0 for 20 cycles after valid → fields stable, `test_delay` unchanged, no new SETTLE; ready=1 → next point proceeds at the following cycle.
- Wrap/step edge cases:
  - first=250, last=255, step=4, SIZE_DELAY=8 → points 250, 254 only (258 overflows).
  - step=0 → single point.
  - first=9, last=3 → single point at 9.
- Zero lengths and ignored start: settle=0, window=0 → MEASURE at cycle 1, one sample, valid at cycle 2. A `start` pulsed while busy → no effect on sequence or cfg.

Source files
------------

// File: rtl/filter_sweep_ctrl.sv
// Delay-sweep sequencer for the filter bench: drives generator test controls,
// settles, measures the signed peak of a filter output and reports each point.
module filter_sweep_ctrl #(
    parameter int SIZE_DELAY       = 8,
    parameter int SIZE_FILTER_DATA = 16,
    parameter int SIZE_CNT         = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        cfg_overlay,
    input  logic                        cfg_rate,
    input  logic [SIZE_DELAY-1:0]       cfg_delay_first,
    input  logic [SIZE_DELAY-1:0]       cfg_delay_last,
    input  logic [SIZE_DELAY-1:0]       cfg_delay_step,
    input  logic [SIZE_CNT-1:0]         cfg_settle_len,
    input  logic [SIZE_CNT-1:0]         cfg_window_len,
    input  logic [SIZE_FILTER_DATA-1:0] filter_data,
    input  logic                        result_ready,
    output logic                        test_overlay,
    output logic                        test_rate,
    output logic [SIZE_DELAY-1:0]       test_delay,
    output logic                        busy,
    output logic                        done,
    output logic                        result_valid,
    output logic [SIZE_DELAY-1:0]       result_delay,
    output logic [SIZE_FILTER_DATA-1:0] result_peak,
    output logic [SIZE_CNT-1:0]         result_peak_pos
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_REPORT
    } state_t;

    state_t state_q, state_d;

    logic overlay_q, overlay_d;
    logic rate_q, rate_d;
    logic [SIZE_DELAY-1:0] delay_q, delay_d;
    logic [SIZE_DELAY-1:0] last_q, last_d;
    logic [SIZE_DELAY-1:0] step_q, step_d;
    logic [SIZE_CNT-1:0] settle_q, settle_d;
    logic [SIZE_CNT-1:0] win_last_q, win_last_d;
    logic [SIZE_CNT-1:0] cnt_q, cnt_d;
    logic signed [SIZE_FILTER_DATA-1:0] peak_q, peak_d;
    logic [SIZE_CNT-1:0] pos_q, pos_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic valid_q, valid_d;
    logic [SIZE_DELAY-1:0] res_delay_q, res_delay_d;
    logic signed [SIZE_FILTER_DATA-1:0] res_peak_q, res_peak_d;
    logic [SIZE_CNT-1:0] res_pos_q, res_pos_d;

    logic [SIZE_DELAY:0] next_sum;
    logic more;
    logic signed [SIZE_FILTER_DATA-1:0] sample;

    // Extra bit exposes the carry so a wrapped delay ends the sweep.
    assign next_sum = {1'b0, delay_q} + {1'b0, step_q};
    assign more = (step_q != '0) && !next_sum[SIZE_DELAY] &&
                  (next_sum[SIZE_DELAY-1:0] <= last_q);
    assign sample = $signed(filter_data);

    always_comb begin
        state_d     = state_q;
        overlay_d   = overlay_q;
        rate_d      = rate_q;
        delay_d     = delay_q;
        last_d      = last_q;
        step_d      = step_q;
        settle_d    = settle_q;
        win_last_d  = win_last_q;
        cnt_d       = cnt_q;
        peak_d      = peak_q;
        pos_d       = pos_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        valid_d     = valid_q;
        res_delay_d = res_delay_q;
        res_peak_d  = res_peak_q;
        res_pos_d   = res_pos_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    overlay_d  = cfg_overlay;
                    rate_d     = cfg_rate;
                    delay_d    = cfg_delay_first;
                    last_d     = cfg_delay_last;
                    step_d     = cfg_delay_step;
                    settle_d   = cfg_settle_len;
                    win_last_d = (cfg_window_len == '0) ? '0
                               : cfg_window_len - SIZE_CNT'(1);
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = (cfg_settle_len == '0) ? S_MEASURE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == settle_q - SIZE_CNT'(1)) begin
                    cnt_d   = '0;
                    state_d = S_MEASURE;
                end else begin
                    cnt_d = cnt_q + SIZE_CNT'(1);
                end
            end
            S_MEASURE: begin
                // Strict compare keeps the earliest position on ties.
                if ((cnt_q == '0) || (sample > peak_q)) begin
                    peak_d = sample;
                    pos_d  = cnt_q;
                end
                if (cnt_q == win_last_q) begin
                    valid_d     = 1'b1;
                    res_delay_d = delay_q;
                    res_peak_d  = peak_d;
                    res_pos_d   = pos_d;
                    state_d     = S_REPORT;
                end else begin
                    cnt_d = cnt_q + SIZE_CNT'(1);
                end
            end
            S_REPORT: begin
                if (result_ready) begin
                    valid_d = 1'b0;
                    if (more) begin
                        delay_d = next_sum[SIZE_DELAY-1:0];
                        cnt_d   = '0;
                        state_d = (settle_q == '0) ? S_MEASURE : S_SETTLE;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            overlay_q   <= 1'b0;
            rate_q      <= 1'b0;
            delay_q     <= '0;
            last_q      <= '0;
            step_q      <= '0;
            settle_q    <= '0;
            win_last_q  <= '0;
            cnt_q       <= '0;
            peak_q      <= '0;
            pos_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            res_delay_q <= '0;
            res_peak_q  <= '0;
            res_pos_q   <= '0;
        end else begin
            state_q     <= state_d;
            overlay_q   <= overlay_d;
            rate_q      <= rate_d;
            delay_q     <= delay_d;
            last_q      <= last_d;
            step_q      <= step_d;
            settle_q    <= settle_d;
            win_last_q  <= win_last_d;
            cnt_q       <= cnt_d;
            peak_q      <= peak_d;
            pos_q       <= pos_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            res_delay_q <= res_delay_d;
            res_peak_q  <= res_peak_d;
            res_pos_q   <= res_pos_d;
        end
    end

    assign test_overlay    = overlay_q;
    assign test_rate       = rate_q;
    assign test_delay      = delay_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign result_valid    = valid_q;
    assign result_delay    = res_delay_q;
    assign result_peak     = res_peak_q;
    assign result_peak_pos = res_pos_q;

endmodule

// File: tb/tb_filter_sweep_ctrl.sv
// Randomized bench for filter_sweep_ctrl against a point-list / window model.
module tb_filter_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cfg_overlay;
    logic        cfg_rate;
    logic [7:0]  cfg_delay_first;
    logic [7:0]  cfg_delay_last;
    logic [7:0]  cfg_delay_step;
    logic [15:0] cfg_settle_len;
    logic [15:0] cfg_window_len;
    logic [15:0] filter_data;
    logic        result_ready;
    logic        test_overlay;
    logic        test_rate;
    logic [7:0]  test_delay;
    logic        busy;
    logic        done;
    logic        result_valid;
    logic [7:0]  result_delay;
    logic [15:0] result_peak;
    logic [15:0] result_peak_pos;

    typedef struct {
        int first;
        int last;
        int step;
        int settle;
        int window;
        bit ov;
        bit rt;
    } cfg_t;

    int checks = 0;
    int failures = 0;
    int fixed_data[$];

    filter_sweep_ctrl #(
        .SIZE_DELAY(8),
        .SIZE_FILTER_DATA(16),
        .SIZE_CNT(16)
    ) dut (
        .clk(clk),
        .reset(rst),
        .start(start),
        .cfg_overlay(cfg_overlay),
        .cfg_rate(cfg_rate),
        .cfg_delay_first(cfg_delay_first),
        .cfg_delay_last(cfg_delay_last),
        .cfg_delay_step(cfg_delay_step),
        .cfg_settle_len(cfg_settle_len),
        .cfg_window_len(cfg_window_len),
        .filter_data(filter_data),
        .result_ready(result_ready),
        .test_overlay(test_overlay),
        .test_rate(test_rate),
        .test_delay(test_delay),
        .busy(busy),
        .done(done),
        .result_valid(result_valid),
        .result_delay(result_delay),
        .result_peak(result_peak),
        .result_peak_pos(result_peak_pos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " overlay"}, int'(test_overlay), 0);
        chk({tag, " rate"}, int'(test_rate), 0);
        chk({tag, " tdelay"}, int'(test_delay), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " valid"}, int'(result_valid), 0);
        chk({tag, " rdelay"}, int'(result_delay), 0);
        chk({tag, " peak"}, int'(result_peak), 0);
        chk({tag, " pos"}, int'(result_peak_pos), 0);
    endtask

    function automatic cfg_t mk(int f, int l, int st, int se, int w);
        cfg_t c;
        c.first  = f;
        c.last   = l;
        c.step   = st;
        c.settle = se;
        c.window = w;
        c.ov     = 1'($urandom);
        c.rt     = 1'($urandom);
        return c;
    endfunction

    task automatic scramble_cfg();
        cfg_overlay     = 1'($urandom);
        cfg_rate        = 1'($urandom);
        cfg_delay_first = 8'($urandom);
        cfg_delay_last  = 8'($urandom);
        cfg_delay_step  = 8'($urandom);
        cfg_settle_len  = 16'($urandom_range(0, 9));
        cfg_window_len  = 16'($urandom_range(0, 9));
    endtask

    // mode 0: ready always; 1: random ready; 2: ready low for 20 valid cycles
    task automatic run_sweep(input cfg_t cf, input int mode, input bit noise);
        int pts[$];
        int win[$];
        int d, n, k, t0, tdone, s, w, vcnt, idx, best, bpos;
        bit exp_v, rdy, fin;
        d = cf.first;
        forever begin
            pts.push_back(d);
            n = d + cf.step;
            if (cf.step == 0 || n > 255 || n > cf.last) break;
            d = n;
        end
        s = cf.settle;
        w = (cf.window == 0) ? 1 : cf.window;

        @(negedge clk);
        start           = 1'b1;
        cfg_overlay     = cf.ov;
        cfg_rate        = cf.rt;
        cfg_delay_first = 8'(cf.first);
        cfg_delay_last  = 8'(cf.last);
        cfg_delay_step  = 8'(cf.step);
        cfg_settle_len  = 16'(cf.settle);
        cfg_window_len  = 16'(cf.window);
        filter_data     = 16'($urandom);
        result_ready    = 1'b0;
        @(posedge clk);

        k = 0;
        t0 = 1;
        tdone = -1;
        vcnt = 0;
        fin = 1'b0;
        for (int c = 1; c < 5000 && !fin; c++) begin
            @(negedge clk);
            exp_v = (tdone < 0) && (c >= t0 + s + w);
            chk("busy", int'(busy), int'(c != tdone));
            chk("done", int'(done), int'(c == tdone));
            chk("valid", int'(result_valid), int'(exp_v));
            chk("test_delay", int'(test_delay), pts[k]);
            chk("test_overlay", int'(test_overlay), int'(cf.ov));
            chk("test_rate", int'(test_rate), int'(cf.rt));
            if (exp_v) begin
                best = win[0];
                bpos = 0;
                for (int i = 1; i < win.size(); i++) begin
                    if (win[i] > best) begin
                        best = win[i];
                        bpos = i;
                    end
                end
                chk("result_delay", int'(result_delay), pts[k]);
                chk("result_peak", int'($signed(result_peak)), best);
                chk("result_pos", int'(result_peak_pos), bpos);
            end
            if (c == tdone) begin
                start = 1'b0;
                fin = 1'b1;
            end else begin
                start = noise && ($urandom_range(0, 3) == 0);
                if (noise) scramble_cfg();
                idx = c - (t0 + s);
                if (idx >= 0 && idx < w && idx < fixed_data.size())
                    filter_data = 16'(fixed_data[idx]);
                else
                    filter_data = 16'($urandom);
                if (idx >= 0 && idx < w)
                    win.push_back(int'($signed(filter_data)));
                case (mode)
                    0: rdy = 1'b1;
                    1: rdy = ($urandom_range(0, 2) != 0);
                    default: rdy = exp_v ? (vcnt >= 20) : 1'($urandom);
                endcase
                if (exp_v) vcnt++;
                result_ready = rdy;
                @(posedge clk);
                if (exp_v && rdy) begin
                    vcnt = 0;
                    win.delete();
                    if (k + 1 < pts.size()) begin
                        k++;
                        t0 = c + 1;
                    end else begin
                        tdone = c + 1;
                    end
                end
            end
        end
        if (!fin) chk("sweep_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        result_ready = 1'b0;
        filter_data = '0;
        scramble_cfg();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        run_sweep(mk(2, 8, 3, 4, 5), 0, 1'b0);

        fixed_data = '{-5, 7, 3, 7, -100, 6};
        run_sweep(mk(10, 10, 0, 2, 6), 0, 1'b0);
        fixed_data.delete();

        run_sweep(mk(1, 5, 2, 3, 4), 2, 1'b0);
        run_sweep(mk(250, 255, 4, 1, 2), 0, 1'b0);
        run_sweep(mk(7, 100, 0, 2, 3), 1, 1'b0);
        run_sweep(mk(9, 3, 1, 1, 1), 0, 1'b0);
        run_sweep(mk(3, 6, 1, 0, 0), 1, 1'b1);

        // Abandon a sweep in MEASURE; nothing may be reported afterwards.
        @(negedge clk);
        cfg_settle_len = 16'd3;
        cfg_window_len = 16'd8;
        cfg_delay_first = 8'd20;
        cfg_overlay = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        result_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk_zero("async_reset");
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            chk("post_reset_valid", int'(result_valid), 0);
        end
        run_sweep(mk(4, 12, 4, 2, 3), 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            run_sweep(mk($urandom_range(0, 255), $urandom_range(0, 255),
                         $urandom_range(0, 90), $urandom_range(0, 6),
                         $urandom_range(0, 6)), 1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
